// File: rtl/pic_inta_sequencer.sv
// CPU-facing 8259 acknowledge sequencer: raises INT, runs the two-pulse INTA cycle, owns the ISR.
// Optional macro PIC_ROTATE_EN enables automatic priority rotation on EOI.
module pic_inta_sequencer #(
    parameter logic [2:0] SPURIOUS_IDX = 3'd7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_status,
    input  logic [7:0] imr,
    input  logic [4:0] vector_base,
    input  logic       auto_eoi,
    input  logic       eoi,
    input  logic       inta_n,
    output logic       int_out,
    output logic       inta,
    output logic [2:0] highest_priority_idx,
    output logic [7:0] isr,
    output logic [7:0] data_out,
    output logic       data_oe
);

    typedef enum logic [2:0] {IDLE, REQ, ACK1, WAIT2, ACK2} state_t;

    state_t     state_q, state_d;
    logic       prev_inta_n_q;
    logic       int_out_q, int_out_d;
    logic       inta_q, inta_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] isr_q, isr_d;
    logic [7:0] data_out_q, data_out_d;
    logic       data_oe_q, data_oe_d;
    logic       spurious_q, spurious_d;

    logic [7:0] eligible;
    logic [2:0] start_idx;
    logic [2:0] pos;
    logic       cand_valid, isr_valid;
    logic [2:0] cand_idx, isr_idx;
    logic       fall, rise;
    logic [7:0] set_mask, eoi_clr, auto_clr;

`ifdef PIC_ROTATE_EN
    logic [2:0] lowest_ptr_q, lowest_ptr_d;
    assign start_idx = lowest_ptr_q + 3'd1;
`else
    assign start_idx = 3'd0;
`endif

    assign eligible = irq_status & ~imr;
    assign fall     = prev_inta_n_q & ~inta_n;
    assign rise     = ~prev_inta_n_q & inta_n;

    // Walk the priority order once; the first in-service level blocks itself and everything after it.
    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = 3'd0;
        isr_valid  = 1'b0;
        isr_idx    = 3'd0;
        pos        = start_idx;
        for (int k = 0; k < 8; k++) begin
            pos = start_idx + 3'(k);
            if (!isr_valid && isr_q[pos]) begin
                isr_valid = 1'b1;
                isr_idx   = pos;
            end
            if (!isr_valid && !cand_valid && eligible[pos]) begin
                cand_valid = 1'b1;
                cand_idx   = pos;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        int_out_d  = int_out_q;
        inta_d     = 1'b0;
        idx_d      = idx_q;
        data_out_d = data_out_q;
        data_oe_d  = data_oe_q;
        spurious_d = spurious_q;
        set_mask   = 8'h00;
        auto_clr   = 8'h00;
        eoi_clr    = (eoi && isr_valid) ? (8'h01 << isr_idx) : 8'h00;

        unique case (state_q)
            IDLE: begin
                if (cand_valid) begin
                    int_out_d = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (fall) begin
                    int_out_d = 1'b0;
                    state_d   = ACK1;
                    if (cand_valid) begin
                        idx_d      = cand_idx;
                        set_mask   = 8'h01 << cand_idx;
                        inta_d     = 1'b1;
                        spurious_d = 1'b0;
                    end else begin
                        idx_d      = SPURIOUS_IDX;
                        spurious_d = 1'b1;
                    end
                end else if (!cand_valid) begin
                    int_out_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            ACK1: begin
                if (rise) state_d = WAIT2;
            end
            WAIT2: begin
                if (fall) begin
                    data_out_d = {vector_base, idx_q};
                    data_oe_d  = 1'b1;
                    state_d    = ACK2;
                end
            end
            ACK2: begin
                if (rise) begin
                    data_out_d = 8'h00;
                    data_oe_d  = 1'b0;
                    state_d    = IDLE;
                    if (auto_eoi && !spurious_q) auto_clr = 8'h01 << idx_q;
                end
            end
            default: state_d = IDLE;
        endcase

        // EOI uses the pre-set ISR so a coincident first INTA still lands its bit.
        isr_d = (isr_q & ~eoi_clr & ~auto_clr) | set_mask;
    end

`ifdef PIC_ROTATE_EN
    always_comb begin
        lowest_ptr_d = lowest_ptr_q;
        if (eoi && isr_valid) lowest_ptr_d = isr_idx;
        if (auto_clr != 8'h00) lowest_ptr_d = idx_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) lowest_ptr_q <= 3'd7;
        else        lowest_ptr_q <= lowest_ptr_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            prev_inta_n_q <= 1'b1;
            int_out_q     <= 1'b0;
            inta_q        <= 1'b0;
            idx_q         <= 3'd0;
            isr_q         <= 8'h00;
            data_out_q    <= 8'h00;
            data_oe_q     <= 1'b0;
            spurious_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_inta_n_q <= inta_n;
            int_out_q     <= int_out_d;
            inta_q        <= inta_d;
            idx_q         <= idx_d;
            isr_q         <= isr_d;
            data_out_q    <= data_out_d;
            data_oe_q     <= data_oe_d;
            spurious_q    <= spurious_d;
        end
    end

    assign int_out              = int_out_q;
    assign inta                 = inta_q;
    assign highest_priority_idx = idx_q;
    assign isr                  = isr_q;
    assign data_out             = data_out_q;
    assign data_oe              = data_oe_q;

endmodule
